// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch/issue stage. It holds the PC and issues one outstanding request at a
//   time to instruction memory. Returned words go into a small prefetch FIFO,
//   and one instruction per cycle is presented to decode. A taken branch
//   flushes the FIFO, drops any in-flight data and restarts at the target.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr    registered memory request and its address
//   imem_ack/imem_rdata   response strobe and returned instruction word
//   stall                 decode hold; freezes the output instruction
//   branch_taken/_target  redirect pulse and its address
//   instruction, instruction_pc, instruction_valid   registered issue outputs
//   fifo_count            prefetch FIFO occupancy
//
// Optional build macro IFU_PERF_COUNT_EN adds the saturating counters
// perf_fetch_count (words pushed) and perf_flush_count (branches taken).
module instruction_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned PC_STEP    = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic                          imem_req,
    output logic [ADDR_WIDTH-1:0]         imem_addr,
    input  logic                          imem_ack,
    input  logic [31:0]                   imem_rdata,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [ADDR_WIDTH-1:0]         branch_target,
    output logic [31:0]                   instruction,
    output logic [ADDR_WIDTH-1:0]         instruction_pc,
    output logic                          instruction_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef IFU_PERF_COUNT_EN
    ,
    output logic [15:0]                   perf_fetch_count,
    output logic [15:0]                   perf_flush_count
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] RESET_C = ADDR_WIDTH'(RESET_PC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n, addr_n;
    logic                  req_n;
    logic [31:0]           fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_n;
    logic                  push, pop;

    // Branch overrides everything: no push of same-cycle data, no pop.
    assign push = (state == S_WAIT) && imem_ack && !branch_taken;
    assign pop  = !branch_taken && !stall && (fifo_count != '0);

    always_comb begin
        count_n = fifo_count;
        if (branch_taken)
            count_n = '0;
        else if (push && !pop)
            count_n = fifo_count + CW'(1);
        else if (!push && pop)
            count_n = fifo_count - CW'(1);
    end

    // pc tracks the address of the outstanding request while in S_WAIT and
    // advances only when that request is acknowledged.
    always_comb begin
        state_n = state;
        req_n   = imem_req;
        addr_n  = imem_addr;
        pc_n    = pc;
        if (branch_taken) begin
            pc_n = branch_target;
            case (state)
                S_WAIT, S_DISCARD: begin
                    // The in-flight request must still complete; keep req/addr.
                    if (imem_ack) begin
                        state_n = S_IDLE;
                        req_n   = 1'b0;
                    end else begin
                        state_n = S_DISCARD;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo_count < DEPTH_C) begin
                        state_n = S_WAIT;
                        req_n   = 1'b1;
                        addr_n  = pc;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        pc_n = pc + STEP_C;
                        if (count_n < DEPTH_C) begin
                            addr_n = pc + STEP_C;
                        end else begin
                            state_n = S_IDLE;
                            req_n   = 1'b0;
                        end
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        state_n = S_IDLE;
                        req_n   = 1'b0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pc        <= RESET_C;
            imem_req  <= 1'b0;
            imem_addr <= RESET_C;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
        end
    end

    // FIFO storage needs no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            fifo_count <= count_n;
            if (branch_taken) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instruction       <= '0;
            instruction_pc    <= '0;
            instruction_valid <= 1'b0;
        end else if (branch_taken) begin
            instruction       <= '0;
            instruction_valid <= 1'b0;
        end else if (!stall) begin
            if (pop) begin
                instruction       <= fifo_data[rd_ptr];
                instruction_pc    <= fifo_pc[rd_ptr];
                instruction_valid <= 1'b1;
            end else begin
                instruction       <= '0;
                instruction_valid <= 1'b0;
            end
        end
    end

`ifdef IFU_PERF_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_count <= '0;
            perf_flush_count <= '0;
        end else begin
            if (push && (perf_fetch_count != '1))
                perf_fetch_count <= perf_fetch_count + 16'd1;
            if (branch_taken && (perf_flush_count != '1))
                perf_flush_count <= perf_flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: table-driven cycle vectors plus
// directed sequences for wait-state memory, branch-during-request and
// PC wrap / asynchronous reset on a second instance with RESET_PC=0xF8.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        reset_n, stall, branch_taken;
    logic [7:0]  branch_target;
    logic        imem_req, imem_ack;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata, instruction;
    logic [7:0]  instruction_pc;
    logic        instruction_valid;
    logic [2:0]  fifo_count;

    // Wrap-test instance
    logic        rst_w_n;
    logic        req_w, ack_w;
    logic [7:0]  addr_w;
    logic [31:0] rdata_w, instr_w;
    logic [7:0]  ipc_w;
    logic        valid_w;
    logic [2:0]  cnt_w;

`ifdef IFU_PERF_COUNT_EN
    logic [15:0] pf_fetch, pf_flush, pf_fetch_w, pf_flush_w;
`endif

    // Memory model: ack after ack_delay cycles of req being high
    int unsigned ack_delay = 0;
    int unsigned wait_cnt  = 0;
    assign imem_ack   = imem_req && (wait_cnt == ack_delay);
    assign imem_rdata = {24'h0, imem_addr};
    always @(posedge clk) begin
        if (!reset_n || !imem_req || imem_ack) wait_cnt <= 0;
        else                                   wait_cnt <= wait_cnt + 1;
    end

    assign ack_w   = req_w;
    assign rdata_w = {24'h0, addr_w};

    instruction_fetch_unit #(
        .ADDR_WIDTH(8), .FIFO_DEPTH(4), .RESET_PC(0), .PC_STEP(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .instruction(instruction), .instruction_pc(instruction_pc),
        .instruction_valid(instruction_valid), .fifo_count(fifo_count)
`ifdef IFU_PERF_COUNT_EN
        , .perf_fetch_count(pf_fetch), .perf_flush_count(pf_flush)
`endif
    );

    instruction_fetch_unit #(
        .ADDR_WIDTH(8), .FIFO_DEPTH(4), .RESET_PC(8'hF8), .PC_STEP(4)
    ) dut_w (
        .clk(clk), .reset_n(rst_w_n),
        .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(ack_w), .imem_rdata(rdata_w),
        .stall(1'b0), .branch_taken(1'b0), .branch_target(8'h00),
        .instruction(instr_w), .instruction_pc(ipc_w),
        .instruction_valid(valid_w), .fifo_count(cnt_w)
`ifdef IFU_PERF_COUNT_EN
        , .perf_fetch_count(pf_fetch_w), .perf_flush_count(pf_flush_w)
`endif
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    typedef struct {
        logic        restart;
        logic        stall;
        logic        br;
        logic [7:0]  tgt;
        logic [31:0] e_instr;
        logic [7:0]  e_pc;
        logic        e_valid;
        logic [2:0]  e_cnt;
        logic        e_req;
        logic [7:0]  e_addr;
    } vec_t;

    function automatic vec_t v(logic rs, logic st, logic br, logic [7:0] tgt,
                               logic [31:0] ei, logic [7:0] ep, logic ev,
                               logic [2:0] ec, logic er, logic [7:0] ea);
        vec_t r;
        r.restart = rs; r.stall = st; r.br = br; r.tgt = tgt;
        r.e_instr = ei; r.e_pc = ep; r.e_valid = ev;
        r.e_cnt = ec; r.e_req = er; r.e_addr = ea;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_w_n = 1'b0;

        // ---- Table: each row = inputs before one edge, outputs after it ----
        // Zero-wait stream, first word at E2
        tbl.push_back(v(1,0,0,8'h00, 32'h00,8'h00,0,3'd0,1,8'h00)); // E0
        tbl.push_back(v(0,0,0,8'h00, 32'h00,8'h00,0,3'd1,1,8'h04)); // E1
        tbl.push_back(v(0,0,0,8'h00, 32'h00,8'h00,1,3'd1,1,8'h08)); // E2
        tbl.push_back(v(0,0,0,8'h00, 32'h04,8'h04,1,3'd1,1,8'h0C));
        tbl.push_back(v(0,0,0,8'h00, 32'h08,8'h08,1,3'd1,1,8'h10));
        tbl.push_back(v(0,0,0,8'h00, 32'h0C,8'h0C,1,3'd1,1,8'h14));
        // Stall for 8 cycles: FIFO fills to 4, req drops, output frozen
        tbl.push_back(v(1,0,0,8'h00, 32'h00,8'h00,0,3'd0,1,8'h00));
        tbl.push_back(v(0,0,0,8'h00, 32'h00,8'h00,0,3'd1,1,8'h04));
        tbl.push_back(v(0,0,0,8'h00, 32'h00,8'h00,1,3'd1,1,8'h08));
        tbl.push_back(v(0,1,0,8'h00, 32'h00,8'h00,1,3'd2,1,8'h0C));
        tbl.push_back(v(0,1,0,8'h00, 32'h00,8'h00,1,3'd3,1,8'h10));
        for (int i = 0; i < 6; i++)
            tbl.push_back(v(0,1,0,8'h00, 32'h00,8'h00,1,3'd4,0,8'h00));
        tbl.push_back(v(0,0,0,8'h00, 32'h04,8'h04,1,3'd3,0,8'h00));
        tbl.push_back(v(0,0,0,8'h00, 32'h08,8'h08,1,3'd2,1,8'h14));
        tbl.push_back(v(0,0,0,8'h00, 32'h0C,8'h0C,1,3'd2,1,8'h18));
        tbl.push_back(v(0,0,0,8'h00, 32'h10,8'h10,1,3'd2,1,8'h1C));
        tbl.push_back(v(0,0,0,8'h00, 32'h14,8'h14,1,3'd2,1,8'h20));
        // Branch together with stall while FIFO holds 3
        tbl.push_back(v(1,0,0,8'h00, 32'h00,8'h00,0,3'd0,1,8'h00));
        tbl.push_back(v(0,0,0,8'h00, 32'h00,8'h00,0,3'd1,1,8'h04));
        tbl.push_back(v(0,0,0,8'h00, 32'h00,8'h00,1,3'd1,1,8'h08));
        tbl.push_back(v(0,1,0,8'h00, 32'h00,8'h00,1,3'd2,1,8'h0C));
        tbl.push_back(v(0,1,0,8'h00, 32'h00,8'h00,1,3'd3,1,8'h10));
        tbl.push_back(v(0,1,1,8'h40, 32'h00,8'h00,0,3'd0,0,8'h00));
        tbl.push_back(v(0,1,0,8'h00, 32'h00,8'h00,0,3'd0,1,8'h40));
        tbl.push_back(v(0,0,0,8'h00, 32'h00,8'h00,0,3'd1,1,8'h44));
        tbl.push_back(v(0,0,0,8'h00, 32'h40,8'h40,1,3'd1,1,8'h48));

        // ---- Reset state ----
        do_reset();
        check("reset req",   imem_req, 0);
        check("reset addr",  imem_addr, 8'h00);
        check("reset instr", instruction, 32'h0);
        check("reset ipc",   instruction_pc, 8'h00);
        check("reset valid", instruction_valid, 0);
        check("reset count", fifo_count, 3'd0);

        foreach (tbl[i]) begin
            if (tbl[i].restart) do_reset();
            stall         = tbl[i].stall;
            branch_taken  = tbl[i].br;
            branch_target = tbl[i].tgt;
            step();
            check($sformatf("row%0d instr", i), instruction, tbl[i].e_instr);
            check($sformatf("row%0d ipc", i),   instruction_pc, tbl[i].e_pc);
            check($sformatf("row%0d valid", i), instruction_valid, tbl[i].e_valid);
            check($sformatf("row%0d count", i), fifo_count, tbl[i].e_cnt);
            check($sformatf("row%0d req", i),   imem_req, tbl[i].e_req);
            if (tbl[i].e_req)
                check($sformatf("row%0d addr", i), imem_addr, tbl[i].e_addr);
        end
        branch_taken = 1'b0;
        stall        = 1'b0;

        // ---- Three wait cycles per access ----
        ack_delay = 3;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("ws hold%0d req", k),  imem_req, 1);
            check($sformatf("ws hold%0d addr", k), imem_addr, 8'h00);
            check($sformatf("ws hold%0d cnt", k),  fifo_count, 3'd0);
        end
        step();
        check("ws push cnt",  fifo_count, 3'd1);
        check("ws next addr", imem_addr, 8'h04);
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("ws out%0d valid", k), instruction_valid, (k % 4) == 0);
            check($sformatf("ws out%0d instr", k), instruction,
                  ((k % 4) == 0) ? 32'(4 * (k / 4)) : 32'h0);
        end

        // ---- Branch while the 0x10 request is outstanding ----
        ack_delay = 2;
        do_reset();
        for (int n = 0; n < 40 && !(imem_req && imem_addr == 8'h10); n++) step();
        check("br reach 0x10", imem_addr, 8'h10);
        branch_taken  = 1'b1;
        branch_target = 8'h40;
        step();
        branch_taken = 1'b0;
        check("br B req",   imem_req, 1);
        check("br B addr",  imem_addr, 8'h10);
        check("br B valid", instruction_valid, 0);
        check("br B instr", instruction, 32'h0);
        check("br B cnt",   fifo_count, 3'd0);
        step();
        check("br B1 req",   imem_req, 1);
        check("br B1 addr",  imem_addr, 8'h10);
        check("br B1 valid", instruction_valid, 0);
        step();
        check("br B2 req",   imem_req, 0);
        check("br B2 cnt",   fifo_count, 3'd0);
        check("br B2 valid", instruction_valid, 0);
        step();
        check("br B3 req",  imem_req, 1);
        check("br B3 addr", imem_addr, 8'h40);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("br out%0d valid", k), instruction_valid, k == 4);
            check($sformatf("br out%0d instr", k), instruction, (k == 4) ? 32'h40 : 32'h0);
        end
        check("br out pc", instruction_pc, 8'h40);
        ack_delay = 0;

        // ---- PC wrap from 0xF8 and asynchronous reset mid-request ----
        @(posedge clk);
        #1 rst_w_n = 1'b1;
        step();
        check("wrap E0 addr", addr_w, 8'hF8);
        check("wrap E0 req",  req_w, 1);
        step();
        check("wrap E1 addr", addr_w, 8'hFC);
        step();
        check("wrap E2 addr",  addr_w, 8'h00);
        check("wrap E2 instr", instr_w, 32'hF8);
        check("wrap E2 ipc",   ipc_w, 8'hF8);
        check("wrap E2 valid", valid_w, 1);
        step();
        check("wrap E3 addr", addr_w, 8'h04);
        check("wrap E3 ipc",  ipc_w, 8'hFC);
        #2 rst_w_n = 1'b0;
        #1;
        check("arst req",   req_w, 0);
        check("arst addr",  addr_w, 8'hF8);
        check("arst instr", instr_w, 32'h0);
        check("arst ipc",   ipc_w, 8'h00);
        check("arst valid", valid_w, 0);
        check("arst cnt",   cnt_w, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
